// File: rtl/led_apb_sequencer.sv
// led_apb_sequencer: APB master that writes an 8-bit LED pattern to one
// slave register, advances the pattern per MODE, and idles PERIOD cycles.
// Ports: PCLK/PRESETn clock and async active-low reset; EN, MODE, SEED,
// PERIOD control the sequence; PSEL/PENABLE/PWRITE/PADDR/PWDATA/PRDATA form
// the APB master; BUSY (not IDLE), WR_DONE (pulse after each write access)
// and ERR (sticky readback mismatch) report status.
// Optional macro LED_SEQ_READBACK_EN adds a read-back transfer after every
// write and compares the returned byte; without it ERR is tied low.
module led_apb_sequencer #(
    parameter logic [31:0] LED_ADDR = 32'h0000_0000,
    parameter int unsigned PERIOD_W = 16
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    input  logic                EN,
    input  logic [1:0]          MODE,
    input  logic [7:0]          SEED,
    input  logic [PERIOD_W-1:0] PERIOD,
    output logic                PSEL,
    output logic                PENABLE,
    output logic                PWRITE,
    output logic [31:0]         PADDR,
    output logic [31:0]         PWDATA,
    input  logic [31:0]         PRDATA,
    output logic                BUSY,
    output logic                WR_DONE,
    output logic                ERR
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT    = 3'd1,
        S_WSETUP  = 3'd2,
        S_WACCESS = 3'd3
`ifdef LED_SEQ_READBACK_EN
        ,
        S_RSETUP  = 3'd4,
        S_RACCESS = 3'd5
`endif
    } state_e;

    state_e              state_q, state_d;
    logic [7:0]          pat_q, pat_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [1:0]          mode_q, mode_d;
    logic                wr_done_q, wr_done_d;
`ifdef LED_SEQ_READBACK_EN
    logic [7:0]          wpat_q, wpat_d;
    logic                err_q, err_d;
`endif

    // Only the low byte is meaningful; the rest of the bus is ignored.
    logic prdata_unused;
    assign prdata_unused = ^PRDATA;

    function automatic logic [7:0] next_pat(input logic [1:0] m,
                                            input logic [7:0] p);
        logic [7:0] r;
        case (m)
            2'd0:    r = {p[6:0], p[7]};
            2'd1:    r = ~p;
            2'd2:    r = p + 8'd1;
            default: r = p;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        wr_done_d = 1'b0;
`ifdef LED_SEQ_READBACK_EN
        wpat_d    = wpat_q;
        err_d     = err_q;
`endif
        PSEL      = 1'b0;
        PENABLE   = 1'b0;
        PWRITE    = 1'b0;
        PADDR     = 32'h0;
        PWDATA    = 32'h0;

        case (state_q)
            S_IDLE: begin
                if (EN) begin
                    state_d = S_WSETUP;
                    pat_d   = SEED;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                // >= so that lowering PERIOD below cnt starts a write at once
                if (!EN) begin
                    state_d = S_IDLE;
                end else if (cnt_q >= PERIOD) begin
                    state_d = S_WSETUP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WSETUP: begin
                PSEL    = 1'b1;
                PWRITE  = 1'b1;
                PADDR   = LED_ADDR;
                PWDATA  = {24'h0, pat_q};
                // MODE is captured here, so a change during the access
                // cycle only shapes the update after the following write.
                mode_d  = MODE;
                state_d = S_WACCESS;
            end
            S_WACCESS: begin
                PSEL      = 1'b1;
                PENABLE   = 1'b1;
                PWRITE    = 1'b1;
                PADDR     = LED_ADDR;
                PWDATA    = {24'h0, pat_q};
                pat_d     = next_pat(mode_q, pat_q);
                cnt_d     = '0;
                wr_done_d = 1'b1;
`ifdef LED_SEQ_READBACK_EN
                wpat_d    = pat_q;
                state_d   = EN ? S_RSETUP : S_IDLE;
`else
                state_d   = EN ? S_WAIT : S_IDLE;
`endif
            end
`ifdef LED_SEQ_READBACK_EN
            S_RSETUP: begin
                PSEL    = 1'b1;
                PADDR   = LED_ADDR;
                state_d = S_RACCESS;
            end
            S_RACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                PADDR   = LED_ADDR;
                if (PRDATA[7:0] != wpat_q) begin
                    err_d = 1'b1;
                end
                state_d = EN ? S_WAIT : S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= S_IDLE;
            pat_q     <= 8'h0;
            cnt_q     <= '0;
            mode_q    <= 2'd0;
            wr_done_q <= 1'b0;
`ifdef LED_SEQ_READBACK_EN
            wpat_q    <= 8'h0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            wr_done_q <= wr_done_d;
`ifdef LED_SEQ_READBACK_EN
            wpat_q    <= wpat_d;
            err_q     <= err_d;
`endif
        end
    end

    assign BUSY    = (state_q != S_IDLE);
    assign WR_DONE = wr_done_q;
`ifdef LED_SEQ_READBACK_EN
    assign ERR     = err_q;
`else
    assign ERR     = 1'b0;
`endif

endmodule

// File: tb/tb_led_apb_sequencer.sv
// tb_led_apb_sequencer: scoreboard bench for led_apb_sequencer.
// Expected write bytes are queued as each scenario starts and popped by a bus monitor.
module tb_led_apb_sequencer;

    localparam logic [31:0] ADDR = 32'h4000_0010;
    localparam int PW = 16;
`ifdef LED_SEQ_READBACK_EN
    localparam int RB = 2;
`else
    localparam int RB = 0;
`endif
    localparam int C_EMPTY   = 0;
    localparam int C_WAIT    = 1;
    localparam int C_WSETUP  = 2;
    localparam int C_WACCESS = 3;

    logic          PCLK = 1'b0;
    logic          PRESETn;
    logic          EN;
    logic [1:0]    MODE;
    logic [7:0]    SEED;
    logic [PW-1:0] PERIOD;
    logic          PSEL, PENABLE, PWRITE;
    logic [31:0]   PADDR, PWDATA, PRDATA;
    logic          BUSY, WR_DONE, ERR;

    logic          bad_slave;
    logic [31:0]   led_reg;
    int            n_chk = 0;
    int            n_fail = 0;
    int            cyc = 0;
    int            wr_cnt = 0;
    int            done_cnt = 0;
    logic          prev_acc = 1'b0;
    logic [7:0]    exp_q[$];
    int            rise_q[$];

    always #5 PCLK = ~PCLK;

    assign PRDATA = bad_slave ? 32'h0000_0055 : led_reg;

    led_apb_sequencer #(.LED_ADDR(ADDR), .PERIOD_W(PW)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .EN(EN), .MODE(MODE),
        .SEED(SEED), .PERIOD(PERIOD), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .BUSY(BUSY), .WR_DONE(WR_DONE), .ERR(ERR)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge PCLK) cyc <= cyc + 1;

    always @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) led_reg <= 32'h0;
        else if (PSEL && PENABLE && PWRITE) led_reg <= PWDATA;
    end

    // Bus monitor: sampled on the falling edge, mid-cycle.
    always @(negedge PCLK) begin
        if (PRESETn) begin
            check("wr_done", 32'(WR_DONE), 32'(prev_acc));
            if (WR_DONE) done_cnt++;
            if (PSEL) begin
                check("paddr", PADDR, ADDR);
`ifndef LED_SEQ_READBACK_EN
                check("pwrite", 32'(PWRITE), 32'd1);
`endif
            end
            if (PSEL && PWRITE && !PENABLE) rise_q.push_back(cyc);
            if (PSEL && PENABLE && PWRITE) begin
                wr_cnt++;
                check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    check("pwdata", PWDATA, {24'h0, e});
                end
            end
        end
        prev_acc = PRESETn && PSEL && PENABLE && PWRITE;
    end

    function automatic bit cond(input int which);
        case (which)
            C_EMPTY:  return exp_q.size() == 0;
            C_WAIT:   return BUSY && !PSEL;
            C_WSETUP: return PSEL && PWRITE && !PENABLE;
            default:  return PSEL && PWRITE && PENABLE;
        endcase
    endfunction

    task automatic wait_until(input string tag, input int which,
                              input int budget);
        int n;
        bit hit;
        n = 0;
        hit = 1'b0;
        while (!hit && n < budget) begin
            @(negedge PCLK);
            #1;
            hit = cond(which);
            n++;
        end
        check({tag, "_reached"}, 32'(hit), 32'd1);
    endtask

    task automatic check_gaps(input string tag, input int gap);
        for (int i = 1; i < rise_q.size(); i++) begin
            check(tag, rise_q[i] - rise_q[i-1], gap);
        end
        rise_q.delete();
    endtask

    task automatic stop_in_wait(input string tag);
        wait_until(tag, C_WAIT, 60);
        EN = 1'b0;
        repeat (2) @(negedge PCLK);
        #1;
        check({tag, "_busy"}, 32'(BUSY), 32'd0);
    endtask

    task automatic start(input logic [1:0] m, input logic [7:0] s,
                         input logic [PW-1:0] p);
        @(negedge PCLK);
        #1;
        MODE = m;
        SEED = s;
        PERIOD = p;
        rise_q.delete();
        EN = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_wr;
        int base_done;
        PRESETn = 1'b0;
        EN = 1'b0;
        MODE = 2'd0;
        SEED = 8'h0;
        PERIOD = '0;
        bad_slave = 1'b0;
        repeat (3) @(negedge PCLK);
        #1;
        check("rst_psel", 32'(PSEL), 32'd0);
        check("rst_penable", 32'(PENABLE), 32'd0);
        check("rst_pwrite", 32'(PWRITE), 32'd0);
        check("rst_paddr", PADDR, 32'h0);
        check("rst_pwdata", PWDATA, 32'h0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_wr_done", 32'(WR_DONE), 32'd0);
        check("rst_err", 32'(ERR), 32'd0);
        PRESETn = 1'b1;
        repeat (3) @(negedge PCLK);
        #1;
        check("idle_busy", 32'(BUSY), 32'd0);
        check("idle_paddr", PADDR, 32'h0);

        // Running light with idle gaps, then stop from WAIT.
        exp_q.push_back(8'h80);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h02);
        start(2'd0, 8'h80, 16'd4);
        wait_until("rl", C_EMPTY, 100);
        check_gaps("rl_gap", 7 + RB);
        base_wr = wr_cnt;
        stop_in_wait("rl_stop");
        repeat (20) @(negedge PCLK);
        #1;
        check("rl_no_more_wr", wr_cnt, base_wr);

        // Binary count across the 8'hFF wrap, back-to-back.
        exp_q.push_back(8'hFE);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h00);
        start(2'd2, 8'hFE, 16'd0);
        wait_until("cnt", C_EMPTY, 60);
        check_gaps("cnt_gap", 3 + RB);
        stop_in_wait("cnt_stop");

        // Blink restarts from the new seed.
        exp_q.push_back(8'h0F);
        exp_q.push_back(8'hF0);
        exp_q.push_back(8'h0F);
        start(2'd1, 8'h0F, 16'd0);
        wait_until("blk", C_EMPTY, 60);
        check_gaps("blk_gap", 3 + RB);
        stop_in_wait("blk_stop");

        // EN dropped in WSETUP: the write still completes, once.
        exp_q.push_back(8'hA5);
        base_wr = wr_cnt;
        base_done = done_cnt;
        start(2'd3, 8'hA5, 16'd2);
        wait_until("dis", C_WSETUP, 20);
        EN = 1'b0;
        repeat (6) @(negedge PCLK);
        #1;
        check("dis_busy", 32'(BUSY), 32'd0);
        check("dis_wr_cnt", wr_cnt - base_wr, 32'd1);
        check("dis_done_cnt", done_cnt - base_done, 32'd1);
        check("dis_sb_left", exp_q.size(), 32'd0);

        // MODE 0 -> 3 during the first access: one more rotate, then hold.
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h02);
        start(2'd0, 8'h01, 16'd1);
        wait_until("mc", C_WACCESS, 20);
        MODE = 2'd3;
        wait_until("mc", C_EMPTY, 100);
        stop_in_wait("mc_stop");

`ifdef LED_SEQ_READBACK_EN
        // Slave returns 0x55 after 0xAA writes: ERR sets and sticks.
        bad_slave = 1'b1;
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'hAA);
        start(2'd3, 8'hAA, 16'd0);
        wait_until("rb", C_EMPTY, 60);
        stop_in_wait("rb_stop");
        check("rb_err", 32'(ERR), 32'd1);
        bad_slave = 1'b0;
        repeat (5) @(negedge PCLK);
        #1;
        check("rb_err_sticky", 32'(ERR), 32'd1);
`else
        check("err_tied", 32'(ERR), 32'd0);
`endif

        // Asynchronous reset in the middle of a write access.
        exp_q.push_back(8'h3C);
        start(2'd3, 8'h3C, 16'd2);
        wait_until("ar", C_WACCESS, 20);
        #1;
        PRESETn = 1'b0;
        #1;
        check("ar_psel", 32'(PSEL), 32'd0);
        check("ar_penable", 32'(PENABLE), 32'd0);
        check("ar_busy", 32'(BUSY), 32'd0);
        check("ar_err", 32'(ERR), 32'd0);
        EN = 1'b0;
        repeat (2) @(negedge PCLK);
        #1;
        PRESETn = 1'b1;
        base_wr = wr_cnt;
        repeat (5) @(negedge PCLK);
        #1;
        check("ar_idle_busy", 32'(BUSY), 32'd0);
        check("ar_idle_psel", 32'(PSEL), 32'd0);
        check("ar_no_wr", wr_cnt, base_wr);

        // Correct slave: ERR stays low.
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'h5B);
        start(2'd2, 8'h5A, 16'd1);
        wait_until("ok", C_EMPTY, 60);
        stop_in_wait("ok_stop");
        check("ok_err", 32'(ERR), 32'd0);
        check("sb_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
